// File: rtl/coin_input_conditioner_if.sv
// Sensor inputs and coin-code outputs of coin_input_conditioner.
// COIN_REJECT_EN adds the one-cycle reject strobe.
interface coin_input_conditioner_if;
  logic       sense_circle;
  logic       sense_triangle;
  logic       sense_pentagon;
  logic [1:0] CoinValue;
  logic       fifo_full;
  logic       overflow;
`ifdef COIN_REJECT_EN
  logic       reject;

  modport master (
    output sense_circle, sense_triangle, sense_pentagon,
    input  CoinValue, fifo_full, overflow, reject
  );
  modport slave (
    input  sense_circle, sense_triangle, sense_pentagon,
    output CoinValue, fifo_full, overflow, reject
  );
`else
  modport master (
    output sense_circle, sense_triangle, sense_pentagon,
    input  CoinValue, fifo_full, overflow
  );
  modport slave (
    input  sense_circle, sense_triangle, sense_pentagon,
    output CoinValue, fifo_full, overflow
  );
`endif
endinterface

// File: rtl/coin_input_conditioner.sv
// Debounces three raw coin sensors and presents each coin on CoinValue as a hold + gap.
// Optional macro COIN_REJECT_EN: multi-sensor coins are rejected instead of priority-encoded.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int GAP_CYCLES      = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input logic                    clock,
  input logic                    reset,
  coin_input_conditioner_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {D_IDLE, D_QUAL, D_RELEASE, D_RQUAL} det_t;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} seq_t;

  function automatic logic [1:0] encode(input logic [2:0] v);
    if (v[2])      return 2'b11;
    else if (v[1]) return 2'b10;
    else if (v[0]) return 2'b01;
    else           return 2'b00;
  endfunction

  // Two-flop synchronizers; bit order {pentagon, triangle, circle}
  logic [2:0] sync1, sync2, s;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= {bus.sense_pentagon, bus.sense_triangle, bus.sense_circle};
      sync2 <= sync1;
    end
  end
  assign s = sync2;

  // Detector: one acceptance per press, and a debounced release before the next
  det_t            det_state;
  logic [DW-1:0]   det_cnt;
  logic [2:0]      det_v;
  logic            acc_valid;
  logic [1:0]      acc_code;
  logic            reject_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      det_state <= D_IDLE;
      det_cnt   <= '0;
      det_v     <= 3'b000;
      acc_valid <= 1'b0;
      acc_code  <= 2'b00;
      reject_r  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      reject_r  <= 1'b0;
      case (det_state)
        D_IDLE: begin
          if (s != 3'b000) begin
            det_state <= D_QUAL;
            det_cnt   <= DW'(1);
            det_v     <= s;
          end
        end
        D_QUAL: begin
          if (det_cnt == DW'(DEBOUNCE_CYCLES)) begin
            det_state <= D_RELEASE;
            acc_code  <= encode(det_v);
`ifdef COIN_REJECT_EN
            if ($countones(det_v) > 1) reject_r  <= 1'b1;
            else                       acc_valid <= 1'b1;
`else
            acc_valid <= 1'b1;
`endif
          end else if (s != det_v) begin
            if (s == 3'b000) begin
              det_state <= D_IDLE;
            end else begin
              det_v   <= s;
              det_cnt <= DW'(1);
            end
          end else begin
            det_cnt <= det_cnt + DW'(1);
          end
        end
        D_RELEASE: begin
          if (s == 3'b000) begin
            det_state <= D_RQUAL;
            det_cnt   <= DW'(1);
          end
        end
        D_RQUAL: begin
          if (s != 3'b000)                          det_state <= D_RELEASE;
          else if (det_cnt == DW'(DEBOUNCE_CYCLES)) det_state <= D_IDLE;
          else                                      det_cnt   <= det_cnt + DW'(1);
        end
        default: det_state <= D_IDLE;
      endcase
    end
  end

  // FIFO and sequencer handshake: the sequencer takes a code when idle or on
  // the last gap cycle, so queued coins follow each other with exactly GAP_CYCLES of 00.
  seq_t            seq_state;
  logic [HW-1:0]   hold_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [1:0]      cv;
  logic [1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            full_r, ovf_r;
  logic            seq_ready, fifo_empty, fifo_at_max, pop, bypass, push, drop;

  assign seq_ready   = (seq_state == S_IDLE) ||
                       ((seq_state == S_GAP) && (gap_cnt == GW'(GAP_CYCLES)));
  assign fifo_empty  = (count == '0);
  assign fifo_at_max = (count == CW'(FIFO_DEPTH));
  assign pop         = seq_ready && !fifo_empty;
  assign bypass      = seq_ready && fifo_empty && acc_valid;
  assign push        = acc_valid && !bypass && (!fifo_at_max || pop);
  assign drop        = acc_valid && !bypass && fifo_at_max && !pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 2'b00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= acc_code;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count  <= count_nxt;
      full_r <= (count_nxt == CW'(FIFO_DEPTH));
      if (drop) ovf_r <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq_state <= S_IDLE;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      cv        <= 2'b00;
    end else begin
      case (seq_state)
        S_HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES)) begin
            seq_state <= S_GAP;
            cv        <= 2'b00;
            gap_cnt   <= GW'(1);
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          if (!seq_ready) begin
            gap_cnt <= gap_cnt + GW'(1);
          end else if (pop) begin
            seq_state <= S_HOLD;
            cv        <= mem[rd_ptr];
            hold_cnt  <= HW'(1);
          end else if (bypass) begin
            seq_state <= S_HOLD;
            cv        <= acc_code;
            hold_cnt  <= HW'(1);
          end else begin
            seq_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.CoinValue = cv;
  assign bus.fifo_full = full_r;
  assign bus.overflow  = ovf_r;
`ifdef COIN_REJECT_EN
  assign bus.reject    = reject_r;
`endif
endmodule
